axi4_lite_regfile_slave: RTL and testbench
==========================================

Name: axi4_lite_regfile_slave

Overview:
Parametrised AXI4-Lite slave register file: the next generation of the single-FSM AXI-Lite slave.
- Fully independent read and write paths, so a read and a write proceed concurrently.
- AW and W are accepted independently, in either order.
- Byte-lane writes via WSTRB.
- Address decode with DECERR, plus a per-register read-only mask returning SLVERR.
- Sits behind the AXI-Lite interconnect as the bridge's local configuration/status register bank.

Parameters:
DATA_WIDTH, 32, data bus width; 32 or 64.
ADDR_WIDTH, 32, byte-address width.
NUM_REGS, 16, number of DATA_WIDTH registers; 1..256.
RO_MASK, 0, NUM_REGS-bit mask; bit i=1 makes register i read-only (writes give SLVERR).

Ports:
ACLK  in  1  clock; all logic on the rising edge.
ARESET  in  1  asynchronous active-high reset.
S_AWADDR  in  ADDR_WIDTH  write byte address.
S_AWVALID  in  1  write-address valid.
S_AWREADY  out  1  write-address ready.
S_WDATA  in  DATA_WIDTH  write data.
S_WSTRB  in  DATA_WIDTH/8  byte-lane enables.
S_WVALID  in  1  write-data valid.
S_WREADY  out  1  write-data ready.
S_BRESP  out  2  write response.
S_BVALID  out  1  write-response valid.
S_BREADY  in  1  write-response ready.
S_ARADDR  in  ADDR_WIDTH  read byte address.
S_ARVALID  in  1  read-address valid.
S_ARREADY  out  1  read-address ready.
S_RDATA  out  DATA_WIDTH  read data.
S_RRESP  out  2  read response.
S_RVALID  out  1  read-data valid.
S_RREADY  in  1  read-data ready.

Behaviour:
Reset and addressing:
- Reset is asynchronous active-high: ACLK and ARESET; reset is async and active-high, as decided.
- On ARESET: all registers=0, aw_held=w_held=0, BVALID=RVALID=0, BRESP=RRESP=2'b00, RDATA=0, AWREADY=WREADY=ARREADY=1 (combinational from the cleared flags).
- Reset mid-transaction aborts it: no register update and no response is issued afterwards.
- Index = addr >> log2(DATA_WIDTH/8); low byte-offset bits are ignored.
- Index >= NUM_REGS is out of range; upper address bits beyond the index field are ignored.

Write path (max one outstanding):
- Two capture stages, aw_held (address) and w_held (data+strb).
- AWREADY = !aw_held && !BVALID; WREADY = !w_held && !BVALID.
- Commit occurs at the edge where the address is available (held, or handshaking this cycle) AND the data is available.
- At commit: register updated byte-wise for lanes with WSTRB=1; BVALID=1 from the next cycle; both held flags cleared.
- Response codes:
  - out of range: no update, BRESP=2'b11 (DECERR);
  - RO_MASK bit set: no update, BRESP=2'b10 (SLVERR);
  - otherwise BRESP=2'b00.
- WSTRB=0 is a legal no-op write with OKAY.
- BVALID/BRESP hold stable until BREADY; BVALID clears at the handshake edge.
- The next AW/W may handshake in the cycle after BVALID falls.
- Minimum throughput: one write per 2 cycles.

Read path (max one outstanding):
- ARREADY = !RVALID.
- On AR handshake at edge N: RDATA/RRESP registered at edge N; RVALID=1 from the cycle after N.
- Out of range: RDATA=0, RRESP=2'b11. RO registers read normally with OKAY.
- RVALID/RDATA/RRESP hold stable until RREADY; RVALID clears at the handshake edge.

Simultaneous events:
- Read and write handshakes in the same cycle are both serviced.
- Same register read and written at the same edge: the read returns the old (pre-write) value.
- BREADY and a new AW in the same cycle: AW is not accepted that cycle (AWREADY=0 while BVALID=1).

Decomposition:
- Package axi4_lite_pkg:
  - resp enum (OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11);
  - function strb_merge(old, new, strb);
  - localparam helper for index width = $clog2(NUM_REGS).
- One natural sub-module, axi4_lite_regbank: the register array with one byte-enabled write port and one synchronous read port, including the RO_MASK gate.
- Handshake and response logic stays in the top module.

Test Plan:
- Write 0xDEADBEEF to addr 0x08 with WSTRB=4'hF, AW and W in the same cycle, BREADY=1 -> BVALID next cycle with BRESP=00; read of 0x08 returns 0xDEADBEEF with RRESP=00, RVALID one cycle after AR handshake.
- W presented 3 cycles before AW (data 0x11223344, addr 0x04) -> WREADY drops after W capture; commit on the AW edge; BRESP=00; readback returns 0x11223344.
- Reg 2 preset to 0xAABBCCDD, then write 0x00000055 with WSTRB=4'b0001 -> readback 0xAABBCC55; WSTRB=0 -> value unchanged, BRESP=00.
- Write and read of addr 0x40 (index 16 with NUM_REGS=16) -> BRESP=11, RRESP=11, RDATA=0. With RO_MASK[3]=1, write to 0x0C -> BRESP=10 and reg 3 unchanged.
- Hold BREADY=0 for 5 cycles -> BVALID/BRESP stable and AWREADY=WREADY=0 throughout; concurrent read of 0x08 completes normally. Same-edge write 0x1 / read of 0x08 (old value 0x0) -> RDATA=0x0.
- Assert ARESET while aw_held=1 and RVALID=1 -> all outputs return to reset values immediately; no BVALID afterwards; all registers read 0.

Source files
------------

// File: rtl/axi4_lite_pkg.sv
// Shared types and helpers for the AXI4-Lite register file slave.
package axi4_lite_pkg;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } resp_t;

   // Width of the decoded index field above the byte offset. It is wide
   // enough for the largest bank (256 registers), so an index past
   // NUM_REGS decodes as out of range instead of aliasing. Address bits
   // above this field are ignored.
   localparam int IDX_FIELD_W = 8;

   // Widest supported data bus; strb_merge works at this width.
   localparam int MAX_DW = 64;

   // Width of a register slot index; a single-register bank still gets one bit.
   function automatic int idx_width(input int num_regs);
      return (num_regs <= 1) ? 1 : $clog2(num_regs);
   endfunction

   // Replace the bytes of old_v with those of new_v wherever strb is set.
   function automatic logic [MAX_DW-1:0] strb_merge(input logic [MAX_DW-1:0]   old_v,
                                                    input logic [MAX_DW-1:0]   new_v,
                                                    input logic [MAX_DW/8-1:0] strb);
      logic [MAX_DW-1:0] merged;
      merged = old_v;
      for (int b = 0; b < MAX_DW/8; b++) begin
         if (strb[b]) merged[8*b +: 8] = new_v[8*b +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/axi4_lite_regbank.sv
// Register array: one byte-enabled write port, one registered read port,
// index range decode and the read-only gate.
module axi4_lite_regbank
   import axi4_lite_pkg::*;
#(
   parameter int                  DATA_WIDTH = 32,
   parameter int                  NUM_REGS   = 16,
   parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_we,
   input  logic [IDX_FIELD_W-1:0]  i_widx,
   input  logic [DATA_WIDTH-1:0]   i_wdata,
   input  logic [DATA_WIDTH/8-1:0] i_wstrb,
   output resp_t                   o_wresp,
   input  logic                    i_re,
   input  logic [IDX_FIELD_W-1:0]  i_ridx,
   output resp_t                   o_rresp,
   output logic [DATA_WIDTH-1:0]   o_rdata
);

   localparam int                   IW    = idx_width(NUM_REGS);
   localparam logic [IDX_FIELD_W:0] NREGS = (IDX_FIELD_W+1)'(NUM_REGS);

   logic [DATA_WIDTH-1:0] r_mem [NUM_REGS];
   logic [DATA_WIDTH-1:0] r_rdata;
   logic                  w_wr_in;
   logic                  w_rd_in;
   logic [IW-1:0]         w_wr_slot;
   logic [IW-1:0]         w_rd_slot;
   logic [DATA_WIDTH-1:0] w_merged;

   assign w_wr_in   = {1'b0, i_widx} < NREGS;
   assign w_rd_in   = {1'b0, i_ridx} < NREGS;
   assign w_wr_slot = i_widx[IW-1:0];
   assign w_rd_slot = i_ridx[IW-1:0];
   assign w_merged  = DATA_WIDTH'(strb_merge(MAX_DW'(r_mem[w_wr_slot]),
                                             MAX_DW'(i_wdata),
                                             (MAX_DW/8)'(i_wstrb)));
   assign o_rdata   = r_rdata;
   assign o_rresp   = w_rd_in ? OKAY : DECERR;

   // Write response decode: out of range wins over read-only.
   always_comb begin
      o_wresp = OKAY;
      if (!w_wr_in)                o_wresp = DECERR;
      else if (RO_MASK[w_wr_slot]) o_wresp = SLVERR;
   end

   // Byte-enabled write, only for in-range writable slots.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= '0;
      end else if (i_we && (o_wresp == OKAY)) begin
         r_mem[w_wr_slot] <= w_merged;
      end
   end

   // Registered read; sees the pre-write value on a same-edge collision.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)     r_rdata <= '0;
      else if (i_re) r_rdata <= w_rd_in ? r_mem[w_rd_slot] : '0;
   end

endmodule

// File: rtl/axi4_lite_regfile_slave.sv
// AXI4-Lite slave register file with independent read and write paths.
// AW and W are captured separately and committed once both are present.
module axi4_lite_regfile_slave
   import axi4_lite_pkg::*;
#(
   parameter int                  DATA_WIDTH = 32,
   parameter int                  ADDR_WIDTH = 32,
   parameter int                  NUM_REGS   = 16,
   parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
   input  logic                    ACLK,
   input  logic                    ARESET,
   input  logic [ADDR_WIDTH-1:0]   S_AWADDR,
   input  logic                    S_AWVALID,
   output logic                    S_AWREADY,
   input  logic [DATA_WIDTH-1:0]   S_WDATA,
   input  logic [DATA_WIDTH/8-1:0] S_WSTRB,
   input  logic                    S_WVALID,
   output logic                    S_WREADY,
   output logic [1:0]              S_BRESP,
   output logic                    S_BVALID,
   input  logic                    S_BREADY,
   input  logic [ADDR_WIDTH-1:0]   S_ARADDR,
   input  logic                    S_ARVALID,
   output logic                    S_ARREADY,
   output logic [DATA_WIDTH-1:0]   S_RDATA,
   output logic [1:0]              S_RRESP,
   output logic                    S_RVALID,
   input  logic                    S_RREADY
);

   localparam int SHIFT = $clog2(DATA_WIDTH/8);

   logic                    r_aw_held;
   logic [IDX_FIELD_W-1:0]  r_aw_idx;
   logic                    r_w_held;
   logic [DATA_WIDTH-1:0]   r_wdata;
   logic [DATA_WIDTH/8-1:0] r_wstrb;
   logic                    r_bvalid;
   resp_t                   r_bresp;
   logic                    r_rvalid;
   resp_t                   r_rresp;

   logic [IDX_FIELD_W-1:0]  w_aw_field;
   logic [IDX_FIELD_W-1:0]  w_ar_field;
   logic                    w_aw_hs;
   logic                    w_w_hs;
   logic                    w_ar_hs;
   logic                    w_commit;
   logic [IDX_FIELD_W-1:0]  w_widx;
   logic [DATA_WIDTH-1:0]   w_wdata;
   logic [DATA_WIDTH/8-1:0] w_wstrb;
   resp_t                   w_wresp;
   resp_t                   w_rresp;
   logic                    w_unused_addr;

   assign w_aw_field    = S_AWADDR[SHIFT +: IDX_FIELD_W];
   assign w_ar_field    = S_ARADDR[SHIFT +: IDX_FIELD_W];
   assign w_unused_addr = ^{S_AWADDR[ADDR_WIDTH-1:SHIFT+IDX_FIELD_W], S_AWADDR[SHIFT-1:0],
                            S_ARADDR[ADDR_WIDTH-1:SHIFT+IDX_FIELD_W], S_ARADDR[SHIFT-1:0]};

   assign S_AWREADY = !r_aw_held && !r_bvalid;
   assign S_WREADY  = !r_w_held && !r_bvalid;
   assign S_ARREADY = !r_rvalid;
   assign S_BVALID  = r_bvalid;
   assign S_BRESP   = r_bresp;
   assign S_RVALID  = r_rvalid;
   assign S_RRESP   = r_rresp;

   assign w_aw_hs  = S_AWVALID && S_AWREADY;
   assign w_w_hs   = S_WVALID && S_WREADY;
   assign w_ar_hs  = S_ARVALID && S_ARREADY;
   // Either half may come from its holding stage or from this cycle's handshake.
   assign w_commit = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
   assign w_widx   = r_aw_held ? r_aw_idx : w_aw_field;
   assign w_wdata  = r_w_held  ? r_wdata  : S_WDATA;
   assign w_wstrb  = r_w_held  ? r_wstrb  : S_WSTRB;

   axi4_lite_regbank #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_REGS   (NUM_REGS),
      .RO_MASK    (RO_MASK)
   ) u_regbank (
      .i_clk   (ACLK),
      .i_rst   (ARESET),
      .i_we    (w_commit),
      .i_widx  (w_widx),
      .i_wdata (w_wdata),
      .i_wstrb (w_wstrb),
      .o_wresp (w_wresp),
      .i_re    (w_ar_hs),
      .i_ridx  (w_ar_field),
      .o_rresp (w_rresp),
      .o_rdata (S_RDATA)
   );

   // Write path: capture AW/W independently, commit when both are present, then hold B.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_aw_held <= 1'b0;
         r_aw_idx  <= '0;
         r_w_held  <= 1'b0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
         r_bvalid  <= 1'b0;
         r_bresp   <= OKAY;
      end else if (w_commit) begin
         r_aw_held <= 1'b0;
         r_w_held  <= 1'b0;
         r_bvalid  <= 1'b1;
         r_bresp   <= w_wresp;
      end else begin
         if (w_aw_hs) begin
            r_aw_held <= 1'b1;
            r_aw_idx  <= w_aw_field;
         end
         if (w_w_hs) begin
            r_w_held <= 1'b1;
            r_wdata  <= S_WDATA;
            r_wstrb  <= S_WSTRB;
         end
         if (r_bvalid && S_BREADY) r_bvalid <= 1'b0;
      end
   end

   // Read path: response registered at the AR edge, held until RREADY.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_rvalid <= 1'b0;
         r_rresp  <= OKAY;
      end else if (w_ar_hs) begin
         r_rvalid <= 1'b1;
         r_rresp  <= w_rresp;
      end else if (r_rvalid && S_RREADY) begin
         r_rvalid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_axi4_lite_regfile_slave.sv
// Randomised and directed bench for axi4_lite_regfile_slave with a
// transaction-level reference model checked every cycle.
module tb_axi4_lite_regfile_slave;

   localparam int          DW = 32;
   localparam int          AW = 32;
   localparam int          NR = 16;
   localparam logic [15:0] RO = 16'h0008;

   logic          ACLK;
   logic          ARESET;
   logic [AW-1:0] S_AWADDR;
   logic          S_AWVALID;
   logic          S_AWREADY;
   logic [DW-1:0] S_WDATA;
   logic [3:0]    S_WSTRB;
   logic          S_WVALID;
   logic          S_WREADY;
   logic [1:0]    S_BRESP;
   logic          S_BVALID;
   logic          S_BREADY;
   logic [AW-1:0] S_ARADDR;
   logic          S_ARVALID;
   logic          S_ARREADY;
   logic [DW-1:0] S_RDATA;
   logic [1:0]    S_RRESP;
   logic          S_RVALID;
   logic          S_RREADY;

   axi4_lite_regfile_slave #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .NUM_REGS   (NR),
      .RO_MASK    (RO)
   ) dut (
      .ACLK      (ACLK),
      .ARESET    (ARESET),
      .S_AWADDR  (S_AWADDR),
      .S_AWVALID (S_AWVALID),
      .S_AWREADY (S_AWREADY),
      .S_WDATA   (S_WDATA),
      .S_WSTRB   (S_WSTRB),
      .S_WVALID  (S_WVALID),
      .S_WREADY  (S_WREADY),
      .S_BRESP   (S_BRESP),
      .S_BVALID  (S_BVALID),
      .S_BREADY  (S_BREADY),
      .S_ARADDR  (S_ARADDR),
      .S_ARVALID (S_ARVALID),
      .S_ARREADY (S_ARREADY),
      .S_RDATA   (S_RDATA),
      .S_RRESP   (S_RRESP),
      .S_RVALID  (S_RVALID),
      .S_RREADY  (S_RREADY)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s actual=no-handshake required=handshake at %0t", name, $time);
   endtask

   // ---------------- reference model ----------------
   logic [31:0] m_regs [NR];
   bit          m_aw_have, m_w_have, m_b_pend, m_r_pend;
   logic [31:0] m_aw_addr, m_wd, m_rdata;
   logic [3:0]  m_ws;
   logic [1:0]  m_bresp, m_rresp;

   function automatic int idx_of(input logic [31:0] a);
      return int'((a >> 2) & 32'hFF);
   endfunction

   always @(negedge ACLK) begin : model
      bit e_awr, e_wr;
      int ix;
      if (ARESET) begin
         foreach (m_regs[i]) m_regs[i] = 32'h0;
         m_aw_have = 0; m_w_have = 0; m_b_pend = 0; m_r_pend = 0;
         chk("rst_awready", 32'(S_AWREADY), 32'd1);
         chk("rst_wready",  32'(S_WREADY),  32'd1);
         chk("rst_arready", 32'(S_ARREADY), 32'd1);
         chk("rst_bvalid",  32'(S_BVALID),  32'd0);
         chk("rst_rvalid",  32'(S_RVALID),  32'd0);
         chk("rst_bresp",   32'(S_BRESP),   32'd0);
         chk("rst_rresp",   32'(S_RRESP),   32'd0);
         chk("rst_rdata",   S_RDATA,        32'd0);
      end else begin
         e_awr = !m_aw_have && !m_b_pend;
         e_wr  = !m_w_have && !m_b_pend;
         chk("awready", 32'(S_AWREADY), 32'(e_awr));
         chk("wready",  32'(S_WREADY),  32'(e_wr));
         chk("arready", 32'(S_ARREADY), 32'(!m_r_pend));
         chk("bvalid",  32'(S_BVALID),  32'(m_b_pend));
         chk("rvalid",  32'(S_RVALID),  32'(m_r_pend));
         if (m_b_pend) chk("bresp", 32'(S_BRESP), 32'(m_bresp));
         if (m_r_pend) begin
            chk("rdata", S_RDATA, m_rdata);
            chk("rresp", 32'(S_RRESP), 32'(m_rresp));
         end
         // read transaction sees register contents before any write this edge
         if (m_r_pend) begin
            if (S_RREADY) m_r_pend = 0;
         end else if (S_ARVALID) begin
            ix = idx_of(S_ARADDR);
            m_r_pend = 1;
            m_rdata  = (ix < NR) ? m_regs[ix] : 32'h0;
            m_rresp  = (ix < NR) ? 2'b00 : 2'b11;
         end
         if (m_b_pend && S_BREADY) m_b_pend = 0;
         if (e_awr && S_AWVALID) begin
            m_aw_have = 1;
            m_aw_addr = S_AWADDR;
         end
         if (e_wr && S_WVALID) begin
            m_w_have = 1;
            m_wd = S_WDATA;
            m_ws = S_WSTRB;
         end
         if (m_aw_have && m_w_have) begin
            ix = idx_of(m_aw_addr);
            m_aw_have = 0;
            m_w_have  = 0;
            m_b_pend  = 1;
            if (ix >= NR) m_bresp = 2'b11;
            else if (RO[ix]) m_bresp = 2'b10;
            else begin
               m_bresp = 2'b00;
               for (int b = 0; b < 4; b++)
                  if (m_ws[b]) m_regs[ix][8*b +: 8] = m_wd[8*b +: 8];
            end
         end
      end
   end

   // ---------------- channel drivers ----------------
   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic aw_send(input logic [31:0] a, input int dly);
      bit ok;
      ok = 0;
      repeat (dly) tick();
      S_AWADDR = a;
      S_AWVALID = 1'b1;
      for (int c = 0; c < 300 && !ok; c++) begin
         @(negedge ACLK);
         ok = S_AWREADY;
         tick();
      end
      if (!ok) fail_timeout("aw_timeout");
      S_AWVALID = 1'b0;
   endtask

   task automatic w_send(input logic [31:0] d, input logic [3:0] s, input int dly);
      bit ok;
      ok = 0;
      repeat (dly) tick();
      S_WDATA = d;
      S_WSTRB = s;
      S_WVALID = 1'b1;
      for (int c = 0; c < 300 && !ok; c++) begin
         @(negedge ACLK);
         ok = S_WREADY;
         tick();
      end
      if (!ok) fail_timeout("w_timeout");
      S_WVALID = 1'b0;
   endtask

   task automatic ar_send(input logic [31:0] a, input int dly);
      bit ok;
      ok = 0;
      repeat (dly) tick();
      S_ARADDR = a;
      S_ARVALID = 1'b1;
      for (int c = 0; c < 300 && !ok; c++) begin
         @(negedge ACLK);
         ok = S_ARREADY;
         tick();
      end
      if (!ok) fail_timeout("ar_timeout");
      S_ARVALID = 1'b0;
   endtask

   task automatic b_recv(output logic [1:0] r, input int dly);
      bit ok;
      ok = 0;
      r = 2'bxx;
      for (int c = 0; c < 300 && !ok; c++) begin
         @(negedge ACLK);
         ok = S_BVALID;
      end
      if (!ok) begin
         fail_timeout("b_timeout");
         tick();
         return;
      end
      tick();
      repeat (dly) tick();
      S_BREADY = 1'b1;
      @(negedge ACLK);
      r = S_BRESP;
      tick();
      S_BREADY = 1'b0;
   endtask

   task automatic r_recv(output logic [31:0] d, output logic [1:0] r, input int dly);
      bit ok;
      ok = 0;
      d = 'x;
      r = 2'bxx;
      for (int c = 0; c < 300 && !ok; c++) begin
         @(negedge ACLK);
         ok = S_RVALID;
      end
      if (!ok) begin
         fail_timeout("r_timeout");
         tick();
         return;
      end
      tick();
      repeat (dly) tick();
      S_RREADY = 1'b1;
      @(negedge ACLK);
      d = S_RDATA;
      r = S_RRESP;
      tick();
      S_RREADY = 1'b0;
   endtask

   task automatic wr_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         output logic [1:0] r);
      fork
         aw_send(a, 0);
         w_send(d, s, 0);
      join
      b_recv(r, 0);
   endtask

   task automatic rd_txn(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
      ar_send(a, 0);
      r_recv(d, r, 0);
   endtask

   function automatic logic [31:0] rand_addr();
      return 32'(($urandom_range(0, 19) << 2) | $urandom_range(0, 3));
   endfunction

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin : main
      logic [31:0] d;
      logic [1:0]  r;
      ARESET = 1'b1;
      S_AWADDR = '0; S_AWVALID = 0; S_WDATA = '0; S_WSTRB = '0; S_WVALID = 0;
      S_BREADY = 0; S_ARADDR = '0; S_ARVALID = 0; S_RREADY = 0;
      repeat (3) tick();
      ARESET = 1'b0;
      tick();

      // AW and W together, full strobe
      fork
         aw_send(32'h08, 0);
         w_send(32'hDEADBEEF, 4'hF, 0);
      join
      chk("t1_bvalid_next", 32'(S_BVALID), 32'd1);
      chk("t1_bresp", 32'(S_BRESP), 32'd0);
      b_recv(r, 0);
      chk("t1_bresp_hs", 32'(r), 32'd0);
      ar_send(32'h08, 0);
      chk("t1_rvalid_next", 32'(S_RVALID), 32'd1);
      r_recv(d, r, 0);
      chk("t1_rdata", d, 32'hDEADBEEF);
      chk("t1_rresp", 32'(r), 32'd0);

      // W three cycles ahead of AW
      fork
         w_send(32'h11223344, 4'hF, 0);
         aw_send(32'h04, 3);
         begin
            tick();
            chk("t2_wready_low", 32'(S_WREADY), 32'd0);
            chk("t2_no_bvalid", 32'(S_BVALID), 32'd0);
         end
      join
      chk("t2_bvalid_on_aw", 32'(S_BVALID), 32'd1);
      b_recv(r, 0);
      chk("t2_bresp", 32'(r), 32'd0);
      rd_txn(32'h04, d, r);
      chk("t2_rdata", d, 32'h11223344);

      // byte lanes
      wr_txn(32'h08, 32'hAABBCCDD, 4'hF, r);
      wr_txn(32'h08, 32'h00000055, 4'b0001, r);
      chk("t3_strb1_bresp", 32'(r), 32'd0);
      rd_txn(32'h08, d, r);
      chk("t3_strb1_rdata", d, 32'hAABBCC55);
      wr_txn(32'h08, 32'hFFFFFFFF, 4'b0000, r);
      chk("t3_strb0_bresp", 32'(r), 32'd0);
      rd_txn(32'h08, d, r);
      chk("t3_strb0_rdata", d, 32'hAABBCC55);

      // decode error and read-only register
      wr_txn(32'h40, 32'h12345678, 4'hF, r);
      chk("t4_decerr_bresp", 32'(r), 32'd3);
      rd_txn(32'h40, d, r);
      chk("t4_decerr_rresp", 32'(r), 32'd3);
      chk("t4_decerr_rdata", d, 32'h0);
      wr_txn(32'h0C, 32'hCAFEF00D, 4'hF, r);
      chk("t4_ro_bresp", 32'(r), 32'd2);
      rd_txn(32'h0C, d, r);
      chk("t4_ro_rdata", d, 32'h0);
      chk("t4_ro_rresp", 32'(r), 32'd0);

      // B stalled for five cycles while a read completes
      fork
         aw_send(32'h10, 0);
         w_send(32'h0BADF00D, 4'hF, 0);
      join
      fork
         repeat (5) begin
            chk("t5_bvalid_hold", 32'(S_BVALID), 32'd1);
            chk("t5_bresp_hold", 32'(S_BRESP), 32'd0);
            chk("t5_awready_low", 32'(S_AWREADY), 32'd0);
            chk("t5_wready_low", 32'(S_WREADY), 32'd0);
            tick();
         end
         begin
            logic [31:0] d5;
            logic [1:0]  r5;
            rd_txn(32'h08, d5, r5);
            chk("t5_read_during_stall", d5, 32'hAABBCC55);
         end
      join
      b_recv(r, 0);

      // same-edge write and read of one register
      wr_txn(32'h08, 32'h0, 4'hF, r);
      fork
         aw_send(32'h08, 0);
         w_send(32'h1, 4'hF, 0);
         ar_send(32'h08, 0);
      join
      r_recv(d, r, 0);
      chk("t6_same_edge_old", d, 32'h0);
      b_recv(r, 0);
      rd_txn(32'h08, d, r);
      chk("t6_after_write", d, 32'h1);

      // randomised concurrent traffic
      fork
         for (int i = 0; i < 60; i++) aw_send(rand_addr(), $urandom_range(0, 3));
         for (int i = 0; i < 60; i++) w_send($urandom, 4'($urandom), $urandom_range(0, 3));
         begin
            logic [1:0] rb;
            for (int i = 0; i < 60; i++) b_recv(rb, $urandom_range(0, 3));
         end
         for (int i = 0; i < 60; i++) ar_send(rand_addr(), $urandom_range(0, 3));
         begin
            logic [31:0] dr;
            logic [1:0]  rr;
            for (int i = 0; i < 60; i++) r_recv(dr, rr, $urandom_range(0, 2));
         end
      join

      // reset with an address held and a read response pending
      aw_send(32'h08, 0);
      ar_send(32'h08, 0);
      chk("t7_aw_held", 32'(S_AWREADY), 32'd0);
      chk("t7_rvalid_pending", 32'(S_RVALID), 32'd1);
      #2;
      ARESET = 1'b1;
      #1;
      chk("t7_awready", 32'(S_AWREADY), 32'd1);
      chk("t7_wready", 32'(S_WREADY), 32'd1);
      chk("t7_arready", 32'(S_ARREADY), 32'd1);
      chk("t7_rvalid", 32'(S_RVALID), 32'd0);
      chk("t7_bvalid", 32'(S_BVALID), 32'd0);
      chk("t7_rdata", S_RDATA, 32'h0);
      @(posedge ACLK);
      #3;
      ARESET = 1'b0;
      tick();
      w_send(32'hFFFFFFFF, 4'hF, 0);
      repeat (3) begin
         chk("t7_no_bvalid", 32'(S_BVALID), 32'd0);
         tick();
      end
      for (int i = 0; i < NR; i++) begin
         rd_txn(32'(i * 4), d, r);
         chk("t7_reg_cleared", d, 32'h0);
      end

      repeat (2) tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
